// File: rtl/sync_cnt_multi_step.sv
// sync_cnt_multi_step: parametrised synchronous up/down counter with two step
// sizes, parallel load, wrap-or-saturate overflow handling, a one-cycle
// overflow pulse and a sticky overflow flag.
// Optional feature macro: SYNC_CNT_MULTI_STEP_MATCH_EN adds a match compare
// (match_val / match_o) that stops the counter (stopped_o) until reset or load.
module sync_cnt_multi_step #(
   parameter int WIDTH     = 4,
   parameter int STEP1     = 1,
   parameter int STEP2     = 2,
   parameter int SATURATE  = 0,
   parameter int RESET_VAL = 0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             c1,
   input  logic             c2,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
`ifdef SYNC_CNT_MULTI_STEP_MATCH_EN
   input  logic [WIDTH-1:0] match_val,
   output logic             match_o,
   output logic             stopped_o,
`endif
   output logic [WIDTH-1:0] cnt_o,
   output logic             ovf_pulse_o,
   output logic             ovf_o
);

   // Steps are zero-extended into WIDTH+1 bits so the top bit of the
   // result is the carry (up) or the borrow (down).
   localparam logic [WIDTH:0]   STEP1_EXT = (WIDTH+1)'(STEP1);
   localparam logic [WIDTH:0]   STEP2_EXT = (WIDTH+1)'(STEP2);
   localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] MAX_CNT   = {WIDTH{1'b1}};

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             ovf_pulse_q, ovf_pulse_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH:0]   step_amt;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             crossed;
   logic [WIDTH-1:0] stepped_cnt;
   logic             halt;

`ifdef SYNC_CNT_MULTI_STEP_MATCH_EN
   logic match_q, match_d;
   logic stopped_q, stopped_d;

   // Once the counter has matched, c1 steps behave as hold
   assign halt = stopped_q;
`else
   assign halt = 1'b0;
`endif

   // Step arithmetic: carry/borrow detection and the wrapped or clamped result
   always_comb begin
      step_amt    = c2 ? STEP2_EXT : STEP1_EXT;
      sum         = {1'b0, cnt_q} + step_amt;
      diff        = {1'b0, cnt_q} - step_amt;
      crossed     = dir ? diff[WIDTH] : sum[WIDTH];
      stepped_cnt = dir ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
      if ((SATURATE != 0) && crossed) begin
         stepped_cnt = dir ? '0 : MAX_CNT;
      end
   end

   // Next-state selection: load beats stepping, c1=0 (or stopped) holds
   always_comb begin
      cnt_d       = cnt_q;
      ovf_pulse_d = 1'b0;
      ovf_d       = ovf_q & ~clr_ovf;
      if (load) begin
         cnt_d = load_val;
      end else if (c1 && !halt) begin
         cnt_d       = stepped_cnt;
         ovf_pulse_d = crossed;
         // A step that crosses a limit sets the flag even if clr_ovf is high
         if (crossed) begin
            ovf_d = 1'b1;
         end
      end
   end

`ifdef SYNC_CNT_MULTI_STEP_MATCH_EN
   // Compare against the final next count so match_o lines up with cnt_o
   always_comb begin
      match_d   = (cnt_d == match_val);
      stopped_d = (stopped_q & ~load) | match_d;
   end

   // Match/stop state registers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         match_q   <= 1'b0;
         stopped_q <= 1'b0;
      end else begin
         match_q   <= match_d;
         stopped_q <= stopped_d;
      end
   end

   assign match_o   = match_q;
   assign stopped_o = stopped_q;
`endif

   // Counter and overflow state registers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_q       <= RESET_CNT;
         ovf_pulse_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         ovf_pulse_q <= ovf_pulse_d;
         ovf_q       <= ovf_d;
      end
   end

   assign cnt_o       = cnt_q;
   assign ovf_pulse_o = ovf_pulse_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_sync_cnt_multi_step.sv
// Testbench for sync_cnt_multi_step: a default-parameter instance and a
// saturating, wider instance driven from shared controls, both checked
// every cycle against an integer-arithmetic reference model.
module tb_sync_cnt_multi_step;

   localparam int A_W = 4, A_S1 = 1, A_S2 = 2, A_SAT = 0, A_RST = 0, A_MV = 5;
   localparam int B_W = 5, B_S1 = 3, B_S2 = 7, B_SAT = 1, B_RST = 4, B_MV = 20;

`ifdef SYNC_CNT_MULTI_STEP_MATCH_EN
   localparam bit MATCH_EN = 1'b1;
`else
   localparam bit MATCH_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset_n, c1, c2, dir, load, clr_ovf;
   logic [A_W-1:0] load_val_a;
   logic [B_W-1:0] load_val_b;
   logic [A_W-1:0] cnt_a;
   logic [B_W-1:0] cnt_b;
   logic pulse_a, ovf_a, pulse_b, ovf_b;
`ifdef SYNC_CNT_MULTI_STEP_MATCH_EN
   logic [A_W-1:0] match_val_a = A_W'(A_MV);
   logic [B_W-1:0] match_val_b = B_W'(B_MV);
   logic match_a, stopped_a, match_b, stopped_b;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_cnt_a, m_pulse_a, m_ovf_a, m_match_a, m_stop_a;
   int m_cnt_b, m_pulse_b, m_ovf_b, m_match_b, m_stop_b;

   always #5 clock = ~clock;

   sync_cnt_multi_step #(.WIDTH(A_W), .STEP1(A_S1), .STEP2(A_S2),
                         .SATURATE(A_SAT), .RESET_VAL(A_RST)) dut_a (
      .clock(clock), .reset_n(reset_n), .c1(c1), .c2(c2), .dir(dir),
      .load(load), .load_val(load_val_a), .clr_ovf(clr_ovf),
`ifdef SYNC_CNT_MULTI_STEP_MATCH_EN
      .match_val(match_val_a), .match_o(match_a), .stopped_o(stopped_a),
`endif
      .cnt_o(cnt_a), .ovf_pulse_o(pulse_a), .ovf_o(ovf_a));

   sync_cnt_multi_step #(.WIDTH(B_W), .STEP1(B_S1), .STEP2(B_S2),
                         .SATURATE(B_SAT), .RESET_VAL(B_RST)) dut_b (
      .clock(clock), .reset_n(reset_n), .c1(c1), .c2(c2), .dir(dir),
      .load(load), .load_val(load_val_b), .clr_ovf(clr_ovf),
`ifdef SYNC_CNT_MULTI_STEP_MATCH_EN
      .match_val(match_val_b), .match_o(match_b), .stopped_o(stopped_b),
`endif
      .cnt_o(cnt_b), .ovf_pulse_o(pulse_b), .ovf_o(ovf_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Behavioural model: one clock edge, computed with plain integers
   task automatic model_step(input int width, input int step1, input int step2,
                             input int sat, input int rstv, input int mv, input int lv,
                             inout int cnt, inout int pulse, inout int ovf,
                             inout int match, inout int stopped);
      int maxv, s, v;
      bit over;
      maxv = (1 << width) - 1;
      if (!reset_n) begin
         cnt = rstv; pulse = 0; ovf = 0; match = 0; stopped = 0;
         return;
      end
      if (load) begin
         cnt = lv; pulse = 0; ovf = clr_ovf ? 0 : ovf; stopped = 0;
      end else if (c1 && !(MATCH_EN && stopped != 0)) begin
         s = c2 ? step2 : step1;
         v = dir ? cnt - s : cnt + s;
         over = (v < 0) || (v > maxv);
         if (!over)       cnt = v;
         else if (sat != 0) cnt = (v < 0) ? 0 : maxv;
         else             cnt = (v < 0) ? v + maxv + 1 : v - maxv - 1;
         pulse = over ? 1 : 0;
         ovf = over ? 1 : (clr_ovf ? 0 : ovf);
      end else begin
         pulse = 0; ovf = clr_ovf ? 0 : ovf;
      end
      if (MATCH_EN) begin
         match = (cnt == mv) ? 1 : 0;
         if (match != 0) stopped = 1;
      end
   endtask

   // Advance one clock, update the model, compare every output 1 time unit later
   task automatic cycle();
      @(posedge clock);
      model_step(A_W, A_S1, A_S2, A_SAT, A_RST, A_MV, int'(load_val_a),
                 m_cnt_a, m_pulse_a, m_ovf_a, m_match_a, m_stop_a);
      model_step(B_W, B_S1, B_S2, B_SAT, B_RST, B_MV, int'(load_val_b),
                 m_cnt_b, m_pulse_b, m_ovf_b, m_match_b, m_stop_b);
      #1;
      check("a_cnt", 32'(cnt_a), m_cnt_a);
      check("a_pulse", 32'(pulse_a), m_pulse_a);
      check("a_ovf", 32'(ovf_a), m_ovf_a);
      check("b_cnt", 32'(cnt_b), m_cnt_b);
      check("b_pulse", 32'(pulse_b), m_pulse_b);
      check("b_ovf", 32'(ovf_b), m_ovf_b);
`ifdef SYNC_CNT_MULTI_STEP_MATCH_EN
      check("a_match", 32'(match_a), m_match_a);
      check("a_stopped", 32'(stopped_a), m_stop_a);
      check("b_match", 32'(match_b), m_match_b);
      check("b_stopped", 32'(stopped_b), m_stop_b);
`endif
      $display("cyc rst_n=%0b ld=%0b c1=%0b c2=%0b dir=%0b clr=%0b | a cnt=%0d p=%0b o=%0b | b cnt=%0d p=%0b o=%0b",
               reset_n, load, c1, c2, dir, clr_ovf, cnt_a, pulse_a, ovf_a, cnt_b, pulse_b, ovf_b);
   endtask

   initial begin
      m_cnt_a = 0; m_pulse_a = 0; m_ovf_a = 0; m_match_a = 0; m_stop_a = 0;
      m_cnt_b = 0; m_pulse_b = 0; m_ovf_b = 0; m_match_b = 0; m_stop_b = 0;
      reset_n = 1'b0; c1 = 1'b0; c2 = 1'b0; dir = 1'b0; load = 1'b0; clr_ovf = 1'b0;
      load_val_a = '0; load_val_b = '0;

      // Reset state
      cycle();
      check("rst_a_cnt", 32'(cnt_a), 0);
      check("rst_b_cnt", 32'(cnt_b), 4);
      check("rst_a_ovf", 32'(ovf_a), 0);

      // Count up by STEP1 three times: 1, 2, 3 with no overflow
      reset_n = 1'b1; c1 = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         cycle();
         check("up1_cnt", 32'(cnt_a), i);
         check("up1_pulse", 32'(pulse_a), 0);
      end

      // Load 14 then step by 2: wraps to 0, pulse for one cycle, sticky until clr
      load = 1'b1; load_val_a = 4'd14;
      cycle();
      load = 1'b0; c2 = 1'b1;
      cycle();
      check("wrap_cnt", 32'(cnt_a), 0);
      check("wrap_pulse", 32'(pulse_a), 1);
      check("wrap_ovf", 32'(ovf_a), 1);
      c1 = 1'b0;
      cycle();
      check("wrap_pulse_drop", 32'(pulse_a), 0);
      check("wrap_ovf_sticky", 32'(ovf_a), 1);
      clr_ovf = 1'b1;
      cycle();
      check("clr_ovf", 32'(ovf_a), 0);
      clr_ovf = 1'b0;

      // Saturating instance: load 1, step down by 7 twice, clamps at 0 both times
      load = 1'b1; load_val_b = 5'd1;
      cycle();
      load = 1'b0; c1 = 1'b1; c2 = 1'b1; dir = 1'b1;
      cycle();
      check("sat_dn_cnt", 32'(cnt_b), 0);
      check("sat_dn_pulse", 32'(pulse_b), 1);
      cycle();
      check("sat_dn2_cnt", 32'(cnt_b), 0);
      check("sat_dn2_pulse", 32'(pulse_b), 1);

      // Load beats a simultaneous step
      load = 1'b1; load_val_a = 4'd9; load_val_b = 5'd29; dir = 1'b0;
      cycle();
      check("load_wins", 32'(cnt_a), 9);

      // Set beats clear on the sticky flag; saturating up clamps at 31
      load_val_a = 4'd15; clr_ovf = 1'b1;
      cycle();
      load = 1'b0;
      cycle();
      check("set_wins_ovf", 32'(ovf_a), 1);
      check("set_wins_cnt", 32'(cnt_a), 1);
      check("sat_up_cnt", 32'(cnt_b), 31);
      clr_ovf = 1'b0;

      // Reset mid-count discards the step, then hold with c1=0
      load = 1'b1; load_val_a = 4'd6;
      cycle();
      load = 1'b0; reset_n = 1'b0;
      cycle();
      check("midrst_cnt", 32'(cnt_a), 0);
      check("midrst_ovf", 32'(ovf_a), 0);
      reset_n = 1'b1; c1 = 1'b0;
      cycle();
      cycle();
      check("hold_cnt", 32'(cnt_a), 0);

`ifdef SYNC_CNT_MULTI_STEP_MATCH_EN
      // Count to the match value and stop there until a load
      load = 1'b1; load_val_a = 4'd0;
      cycle();
      load = 1'b0; c1 = 1'b1; c2 = 1'b0; dir = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      check("match_cnt", 32'(cnt_a), 5);
      check("match_o", 32'(match_a), 1);
      check("stopped_o", 32'(stopped_a), 1);
      cycle();
      check("stopped_hold", 32'(cnt_a), 5);
      load = 1'b1;
      cycle();
      check("stop_cleared", 32'(stopped_a), 0);
      load = 1'b0;
      cycle();
      check("resume_cnt", 32'(cnt_a), 1);
`endif

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         reset_n    = ($urandom % 50) != 0;
         load       = ($urandom % 10) == 0;
         c1         = ($urandom % 4) != 0;
         c2         = 1'($urandom);
         dir        = 1'($urandom);
         clr_ovf    = ($urandom % 8) == 0;
         load_val_a = A_W'($urandom);
         load_val_b = B_W'($urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_cnt_multi_step.md
Name: sync_cnt_multi_step

Overview:
Parametrised successor of the 4-bit nested-enable synchronous counter. Adds:
- configurable width and step sizes
- up/down direction
- parallel load
- selectable wrap or saturate overflow handling
- per-cycle overflow pulse and sticky overflow flag

It sits beside the CFG/LGraph golden test blocks. It is the reference counter for width-extension and nested-priority lowering checks.

Parameters:
- WIDTH, 4: counter width in bits, >= 2.
- STEP1, 1: increment applied when c1=1, c2=0. Must satisfy 1 <= STEP1 < 2^WIDTH.
- STEP2, 2: increment applied when c1=1, c2=1. Must satisfy 1 <= STEP2 < 2^WIDTH.
- SATURATE, 0: 0 = modulo wrap on overflow/underflow; 1 = clamp at limit.
- RESET_VAL, 0: value of cnt_o after reset. Must be < 2^WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- c1  in  1  count enable.
- c2  in  1  step select; honoured only when c1=1.
- dir  in  1  0 = count up, 1 = count down.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- clr_ovf  in  1  clears sticky ovf_o.
- cnt_o  out  WIDTH  registered count.
- ovf_pulse_o  out  1  registered; high for exactly the cycle following a step that crossed a limit.
- ovf_o  out  1  sticky overflow flag.

Behaviour:
- Interface: one clock named clock. Reset is synchronous and active-low, port reset_n. It is sampled only on the rising edge of clock.
- Reset (reset_n=0 at posedge):
  - cnt_o <= RESET_VAL, ovf_pulse_o <= 0, ovf_o <= 0.
  - All other inputs are ignored.
  - Reset mid-count discards any in-flight step.
- All outputs are registered. There is no combinational input-to-output path. Latency is 1 cycle from input sampling to cnt_o, ovf_pulse_o and ovf_o.
- Next-state priority, highest first:
  1. reset_n=0
  2. load=1: cnt_o <= load_val, ovf_pulse_o <= 0. c1, c2 and dir are ignored.
  3. c1=0: hold. ovf_pulse_o <= 0.
  4. c1=1, c2=0: step by STEP1.
  5. c1=1, c2=1: step by STEP2.
- Step arithmetic:
  - Computed in WIDTH+1 bits, zero-extended operands.
  - Up: sum = {0,cnt_o} + step. Overflow when sum[WIDTH]=1.
  - Down: diff = {0,cnt_o} - step. Underflow when diff[WIDTH]=1, i.e. borrow.
- SATURATE=0:
  - cnt_o <= low WIDTH bits of the result (modulo 2^WIDTH).
  - ovf_pulse_o <= overflow|underflow.
- SATURATE=1:
  - On overflow, cnt_o <= 2^WIDTH-1. On underflow, cnt_o <= 0.
  - ovf_pulse_o <= 1 on either event.
  - If already at the limit and stepping further, the count stays clamped and ovf_pulse_o still asserts.
  - Landing exactly on a limit without crossing it is not an overflow.
- Sticky flag:
  - ovf_o <= 1 in any cycle whose step sets ovf_pulse_o.
  - Otherwise, clr_ovf=1 clears it.
  - If a set and a clear occur in the same cycle, the set wins.
  - load does not affect ovf_o.
- c2 and dir are don't-care when c1=0.
- load_val is don't-care when load=0.

Optional Feature:
SYNC_CNT_MULTI_STEP_MATCH_EN:
- When defined, adds:
  - input match_val [WIDTH]
  - output match_o [1]: registered, high in the cycle after cnt_o's next value equals match_val. The compare uses the post-step, post-clamp, post-load value, so match_o and the matching cnt_o appear in the same cycle.
  - output stopped_o [1]: sticky.
- Once match_o asserts, stopped_o <= 1 and further c1 steps are suppressed, acting as hold.
- stopped_o is cleared only by reset or load.
- match_o and stopped_o reset to 0.
- When not defined, these ports and logic are absent and the counter never stops on its own.

Test Plan:
1. Default params. Reset with RESET_VAL=0. Then c1=1, c2=0, dir=0 for 3 cycles -> cnt_o sequence 1, 2, 3; ovf_pulse_o=0; ovf_o=0.
2. Default params. Load 14, then c1=1, c2=1, dir=0 -> cnt_o=0 (14+2 wraps). ovf_pulse_o=1 for one cycle, then 0. ovf_o stays 1 until clr_ovf=1, then 0.
3. SATURATE=1. Load 1, then c1=1, c2=1, dir=1 -> cnt_o=0, ovf_pulse_o=1. Next down step -> cnt_o=0, ovf_pulse_o=1 again.
4. Default params. Same cycle: load=1 with load_val=9, and c1=1, c2=1 -> cnt_o=9 (load wins). Same cycle: step overflow and clr_ovf=1 -> ovf_o=1 (set wins).
5. Default params. Count at 6; assert reset_n=0 for one cycle while c1=1 -> cnt_o=0 and ovf_o=0 the next cycle. Then c1=0 for 2 cycles -> cnt_o holds 0.
6. With SYNC_CNT_MULTI_STEP_MATCH_EN, match_val=5, STEP1=1, from 0 -> cnt_o stops at 5, match_o=1 in the same cycle as cnt_o=5, stopped_o=1. Further c1=1 -> cnt_o holds 5. Load 0 -> stopped_o=0 and counting resumes.
